// File: rtl/hex_display_pkg.sv
// Shared types and glyph constants for the seven-segment display controller.
// Glyphs are active-low segments a..g in bits [6:0].
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        ENC
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Index 15 (F) first, index 0 last.
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment glyph lookup.
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPH[nibble_i];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: hex or serial double-dabble decimal
// conversion, leading-zero blanking, per-digit DP and overflow dashes.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 20
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VALUE_W-1:0]      in_value,
    input  logic                    in_mode,
    input  logic                    in_blank_lz,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    output logic [8*NUM_DIGITS-1:0] seg_export,
    output logic                    overflow,
    output logic                    done
);

    localparam int ND = NUM_DIGITS;
    localparam int BW = 4 * (ND + 1);
    localparam int SW = 8 * ND;
    localparam int CW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

    state_t             state_q;
    logic               in_ready_q;
    logic               done_q;
    logic               ovf_q;
    logic [SW-1:0]      seg_q;
    logic [VALUE_W-1:0] val_q;
    logic               mode_q;
    logic               blz_q;
    logic [ND-1:0]      dp_q;
    logic [BW-1:0]      bcd_q;
    logic               ov_q;
    logic [CW-1:0]      cnt_q;

    logic [BW-1:0]      adj;
    logic [BW-1:0]      dd_d;
    logic               dd_out;
    logic [VALUE_W+4*ND-1:0] ext;
    logic [BW-1:0]      hex_d;
    logic               hex_ov;
    logic [6:0]         glyph [ND];
    logic [SW-1:0]      seg_d;
    logic               ovf_d;
    logic               lead;

    // One double-dabble step: adjust every digit, then shift in the next bit.
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < ND + 1; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        dd_d   = {adj[BW-2:0], val_q[VALUE_W-1]};
        dd_out = adj[BW-1];
    end

    always_comb begin
        ext    = {{(4*ND){1'b0}}, val_q};
        hex_d  = BW'(ext[4*ND-1:0]);
        hex_ov = 1'b0;
        for (int i = 0; i < VALUE_W; i++) begin
            if (i >= 4 * ND && val_q[i])
                hex_ov = 1'b1;
        end
    end

    for (genvar g = 0; g < ND; g++) begin : g_dec
        seg7_decode u_dec (
            .nibble_i (bcd_q[4*g +: 4]),
            .seg_o    (glyph[g])
        );
    end

    // The extra top digit only fills when the decimal value is too wide.
    always_comb begin
        ovf_d = ov_q | (bcd_q[BW-1 -: 4] != 4'd0);
        lead  = blz_q;
        seg_d = '1;
        for (int k = ND - 1; k >= 0; k--) begin
            lead = lead & (bcd_q[4*k +: 4] == 4'd0) & (k != 0);
            if (ovf_d)
                seg_d[8*k +: 8] = {~dp_q[k], SEG_DASH};
            else if (lead)
                seg_d[8*k +: 8] = {~dp_q[k], SEG_BLANK};
            else
                seg_d[8*k +: 8] = {~dp_q[k], glyph[k]};
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            seg_q      <= '1;
            val_q      <= '0;
            mode_q     <= 1'b0;
            blz_q      <= 1'b0;
            dp_q       <= '0;
            bcd_q      <= '0;
            ov_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        val_q      <= in_value;
                        mode_q     <= in_mode;
                        blz_q      <= in_blank_lz;
                        dp_q       <= in_dp;
                        bcd_q      <= '0;
                        ov_q       <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CONV: begin
                    if (!mode_q) begin
                        bcd_q   <= hex_d;
                        ov_q    <= hex_ov;
                        state_q <= ENC;
                    end else begin
                        bcd_q <= dd_d;
                        val_q <= val_q << 1;
                        ov_q  <= ov_q | dd_out;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(VALUE_W - 1))
                            state_q <= ENC;
                    end
                end
                ENC: begin
                    seg_q      <= seg_d;
                    ovf_q      <= ovf_d;
                    done_q     <= 1'b1;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign seg_export = seg_q;
    assign overflow   = ovf_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (6 digits, 20-bit value).
module tb_hex_display_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_value = '0;
    logic        in_mode = 1'b0;
    logic        in_blank_lz = 1'b0;
    logic [5:0]  in_dp = '0;
    logic [47:0] seg_export;
    logic        overflow;
    logic        done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int lat;
    int d0;
    logic busy_ok;

    hex_display_ctrl #(.NUM_DIGITS(6), .VALUE_W(20)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_mode     (in_mode),
        .in_blank_lz (in_blank_lz),
        .in_dp       (in_dp),
        .seg_export  (seg_export),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk_clk = ~clk_clk;

    always @(negedge clk_clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input logic [19:0] v, input logic m,
                            input logic blz, input logic [5:0] dp,
                            output int l);
        @(negedge clk_clk);
        in_valid = 1'b1;
        in_value = v;
        in_mode = m;
        in_blank_lz = blz;
        in_dp = dp;
        @(posedge clk_clk);
        @(negedge clk_clk);
        in_valid = 1'b0;
        l = 0;
        while (done !== 1'b1 && l < 100) begin
            @(posedge clk_clk);
            l++;
            @(negedge clk_clk);
        end
    endtask

    initial begin
        #2 reset_reset = 1'b1;
        @(negedge clk_clk);
        chk("rst_seg", 64'(seg_export), 64'hFFFF_FFFF_FFFF);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        reset_reset = 1'b0;
        @(posedge clk_clk);
        #1 chk("ready_after_rst", 64'(in_ready), 64'd1);

        run_conv(20'h001A3, 1'b0, 1'b1, 6'b0, lat);
        chk("hex1_lat", 64'(lat), 64'd2);
        chk("hex1_seg", 64'(seg_export), 64'hFFFFFF_F988B0);
        chk("hex1_ovf", 64'(overflow), 64'd0);
        chk("hex1_ready", 64'(in_ready), 64'd1);
        @(negedge clk_clk);
        chk("hex1_done_pulse", 64'(done), 64'd0);
        chk("hex1_hold", 64'(seg_export), 64'hFFFFFF_F988B0);

        run_conv(20'hABCDE, 1'b0, 1'b0, 6'b100001, lat);
        chk("hex2_seg", 64'(seg_export), 64'h408883_C6A106);

        run_conv(20'hF0000, 1'b0, 1'b1, 6'b0, lat);
        chk("hex3_seg", 64'(seg_export), 64'hFF8EC0_C0C0C0);

        run_conv(20'd123, 1'b1, 1'b0, 6'b000100, lat);
        chk("dec123_lat", 64'(lat), 64'd21);
        chk("dec123_seg", 64'(seg_export), 64'hC0C0C0_79A4B0);
        chk("dec123_ovf", 64'(overflow), 64'd0);

        run_conv(20'd1048575, 1'b1, 1'b0, 6'b0, lat);
        chk("decmax_seg", 64'(seg_export), 64'hBFBFBF_BFBFBF);
        chk("decmax_ovf", 64'(overflow), 64'd1);

        run_conv(20'd0, 1'b1, 1'b1, 6'b0, lat);
        chk("dec0_seg", 64'(seg_export), 64'hFFFFFF_FFFFC0);
        chk("dec0_ovf", 64'(overflow), 64'd0);

        run_conv(20'd999999, 1'b1, 1'b1, 6'b0, lat);
        chk("dec999999_seg", 64'(seg_export), 64'h909090_909090);
        chk("dec999999_ovf", 64'(overflow), 64'd0);

        run_conv(20'd1000000, 1'b1, 1'b0, 6'b010000, lat);
        chk("dec1e6_seg", 64'(seg_export), 64'hBF3FBF_BFBFBF);
        chk("dec1e6_ovf", 64'(overflow), 64'd1);

        run_conv(20'd5, 1'b1, 1'b1, 6'b0, lat);
        chk("dec5_seg", 64'(seg_export), 64'hFFFFFF_FFFF92);

        @(negedge clk_clk);
        d0 = done_cnt;
        in_valid = 1'b1;
        in_value = 20'd42;
        in_mode = 1'b1;
        in_blank_lz = 1'b0;
        in_dp = 6'b0;
        @(posedge clk_clk);
        @(negedge clk_clk);
        in_value = 20'h7;
        in_mode = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk_clk);
            lat++;
            @(negedge clk_clk);
        end
        chk("b2b_lat", 64'(lat), 64'd21);
        chk("b2b_busy", 64'(busy_ok), 64'd1);
        chk("b2b_first_seg", 64'(seg_export), 64'hC0C0C0_C099A4);
        @(posedge clk_clk);
        @(negedge clk_clk);
        in_valid = 1'b0;
        chk("b2b_second_taken", 64'(in_ready), 64'd0);
        @(posedge clk_clk);
        @(negedge clk_clk);
        @(posedge clk_clk);
        @(negedge clk_clk);
        chk("b2b_second_done", 64'(done), 64'd1);
        chk("b2b_second_seg", 64'(seg_export), 64'hC0C0C0_C0C0F8);
        repeat (5) @(negedge clk_clk);
        #1 chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);

        run_conv(20'd1000000, 1'b1, 1'b0, 6'b0, lat);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        @(negedge clk_clk);
        in_valid = 1'b1;
        in_value = 20'd77;
        in_mode = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk_clk);
        d0 = done_cnt;
        reset_reset = 1'b1;
        #1;
        chk("midrst_seg", 64'(seg_export), 64'hFFFF_FFFF_FFFF);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
        #1 chk("release_ready", 64'(in_ready), 64'd0);
        @(posedge clk_clk);
        #1 chk("release_ready_edge", 64'(in_ready), 64'd1);
        repeat (30) @(negedge clk_clk);
        #1 chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midrst_seg_hold", 64'(seg_export), 64'hFFFF_FFFF_FFFF);

        run_conv(20'h001A3, 1'b0, 1'b1, 6'b000001, lat);
        chk("recover_seg", 64'(seg_export), 64'hFFFFFF_F98830);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of seven-segment digits driven.
REQ-002 SHALL have parameter VALUE_W, default 20: width of the input value.
REQ-003 SHALL have port clk_clk, input, 1: the single clock.
REQ-004 SHALL have port reset_reset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: a new value is offered.
REQ-006 SHALL have port in_ready, output, 1: block is idle and accepts a value.
REQ-007 SHALL have port in_value, input, VALUE_W: unsigned value to display.
REQ-008 SHALL have port in_mode, input, 1: 0 = hex, 1 = decimal.
REQ-009 SHALL have port in_blank_lz, input, 1: blank leading zeros.
REQ-010 SHALL have port in_dp, input, NUM_DIGITS: per-digit decimal point, 1 = lit.
REQ-011 SHALL have port seg_export, output, 8*NUM_DIGITS: byte k drives digit k (digit 0 is least significant); bits[6:0] are segments a..g, active-low; bit7 is DP, active-low.
REQ-012 SHALL have port overflow, output, 1: the last accepted value did not fit.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when seg_export updates.

Function
REQ-014 SHALL implement FSM states IDLE, CONV and ENC; in_ready is 1 only in IDLE.
REQ-015 SHALL capture in_value, in_mode, in_blank_lz and in_dp on a clock edge where in_valid and in_ready are both 1, then enter CONV.
REQ-016 SHALL ignore in_valid outside IDLE; no queuing and no loss of the value in flight.
REQ-017 SHALL, in hex mode, spend 1 cycle in CONV, zero-extending in_value to 4*NUM_DIGITS bits.
REQ-018 SHALL, in decimal mode, spend VALUE_W cycles in CONV running serial double-dabble, one bit per cycle (add 3 to each BCD digit >= 5, then shift), over NUM_DIGITS+1 BCD digits.
REQ-019 SHALL set overflow in hex mode if any in_value bit at index >= 4*NUM_DIGITS is 1.
REQ-020 SHALL set overflow in decimal mode if a 1 shifts out of the top BCD digit or the extra digit is nonzero at the end of CONV.
REQ-021 SHALL spend 1 cycle in ENC, then register seg_export and pulse done on the edge leaving ENC.
REQ-022 Latency from the accept edge to the seg_export/done edge SHALL be 2 cycles in hex mode and VALUE_W+1 cycles in decimal mode.
REQ-023 SHALL hold seg_export stable between updates.
REQ-024 SHALL use glyph encodings 0-9 and A-F per the shared table: blank = 7'h7F; dash = 7'h3F (segment g only).
REQ-025 SHALL drive every digit as a dash on overflow; DP is still applied.
REQ-026 SHALL, when in_blank_lz = 1, blank all digits above the most significant nonzero digit; digit 0 is never blanked.
REQ-027 SHALL drive the DP bit from the captured in_dp regardless of blanking.
REQ-028 SHALL update the overflow output together with seg_export.

Reset
REQ-029 SHALL, while reset_reset is high, force state to IDLE, seg_export to all ones (blank, DP off), and overflow, done and in_ready to 0.
REQ-030 SHALL assert in_ready on the first edge after reset release.
REQ-031 SHALL abort any conversion in progress on reset; no done pulse follows.

Structure
REQ-032 SHALL place the FSM state enum, SEG_BLANK, SEG_DASH and the 16-entry glyph table in the package hex_display_pkg.
REQ-033 SHALL place the nibble-to-glyph decode in the combinational sub-module seg7_decode, with one instance per digit.

Verification (NUM_DIGITS=6, VALUE_W=20)
REQ-034 Hex 0x001A3, blank_lz=1, dp=0 -> after 2 cycles: seg_export=48'hFFFFFF_F988B0, done pulse, overflow=0.
REQ-035 Decimal 123, blank_lz=0, dp=6'b000100 -> after 21 cycles: seg_export=48'hC0C0C0_79A4B0.
REQ-036 Decimal 1048575 -> all bytes 8'hBF, overflow=1; then decimal 0 with blank_lz=1 -> 48'hFFFFFF_FFFFC0, overflow=0.
REQ-037 in_valid held high across a decimal conversion with a second value -> second value accepted only on the edge after done; exactly 2 done pulses.
REQ-038 reset_reset asserted mid-CONV -> seg_export=all 1s immediately, no done pulse, in_ready=1 one edge after release.
